// File: rtl/wordle_pkg.sv
// Shared Wordle types and constants: letter/cell encoding, colours, evaluator states.
package wordle_pkg;

    localparam int LETTER_W = 5;
    localparam int CELL_W   = 7;
    localparam int COLOR_W  = 2;

    localparam logic [COLOR_W-1:0] COLOR_GREY   = 2'd0;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW = 2'd1;
    localparam logic [COLOR_W-1:0] COLOR_GREEN  = 2'd2;

    localparam logic [LETTER_W-1:0] LETTER_A = 5'd1;
    localparam logic [LETTER_W-1:0] LETTER_Z = 5'd26;

    // colour sits in the upper bits so a packed cell reads {colour, letter}
    typedef struct packed {
        logic [COLOR_W-1:0]  colour;
        logic [LETTER_W-1:0] letter;
    } cell_t;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} eval_state_t;

    function automatic logic letter_ok(input logic [LETTER_W-1:0] l);
        return (l >= LETTER_A) && (l <= LETTER_Z);
    endfunction

endpackage

// File: rtl/match_finder.sv
// Finds the lowest answer slot that holds the given letter and is not yet claimed.
module match_finder
    import wordle_pkg::*;
#(
    parameter int NUM_COLS = 5
) (
    input  logic [LETTER_W-1:0]          letter,
    input  logic [NUM_COLS*LETTER_W-1:0] answer,
    input  logic [NUM_COLS-1:0]          used,
    output logic                         found,
    output logic [NUM_COLS-1:0]          slot
);

    logic [NUM_COLS-1:0][LETTER_W-1:0] ans_w;
    logic [NUM_COLS-1:0]               hit;

    assign ans_w = answer;

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_hit
        assign hit[i] = !used[i] && (ans_w[i] == letter);
    end

    // isolate the lowest set bit
    assign slot  = hit & (~hit + {{(NUM_COLS-1){1'b0}}, 1'b1});
    assign found = |hit;

endmodule

// File: rtl/guess_evaluator.sv
// Scores a 5-letter guess against the answer (greens pass, then yellows) and tracks rows/win/game over.
module guess_evaluator
    import wordle_pkg::*;
#(
    parameter int MAX_GUESSES = 6,
    parameter int NUM_COLS    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_game,
    input  logic                         submit,
    input  logic [NUM_COLS*LETTER_W-1:0] guess,
    input  logic [NUM_COLS*LETTER_W-1:0] answer,
    output logic                         busy,
    output logic                         result_valid,
    output logic [NUM_COLS*CELL_W-1:0]   result,
    output logic [2:0]                   row_index,
    output logic                         reject,
    output logic                         win,
    output logic                         game_over
);

    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
    localparam logic [2:0] MAX_ROW  = 3'(MAX_GUESSES);

    typedef logic [NUM_COLS-1:0][LETTER_W-1:0] word_t;

    eval_state_t state_q, state_d;

    word_t                             guess_w, g_q, a_q;
    logic [2:0]                        col_q, col_inc, row_next;
    logic [NUM_COLS-1:0]               used_q, mf_slot;
    logic [NUM_COLS-1:0][COLOR_W-1:0]  colour_q;
    cell_t [NUM_COLS-1:0]              result_q, result_d;
    logic                              mf_found, guess_ok, all_green;
    logic                              load, bad_guess, green_step, yellow_step, finish;

    assign guess_w  = guess;
    assign result   = result_q;
    assign col_inc  = (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;
    assign row_next = (row_index == MAX_ROW) ? row_index : row_index + 3'd1;

    always_comb begin
        guess_ok  = 1'b1;
        all_green = 1'b1;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!letter_ok(guess_w[i]))      guess_ok  = 1'b0;
            if (colour_q[i] != COLOR_GREEN)  all_green = 1'b0;
            result_d[i].colour = colour_q[i];
            result_d[i].letter = g_q[i];
        end
    end

    match_finder #(.NUM_COLS(NUM_COLS)) u_match (
        .letter (g_q[col_q]),
        .answer (a_q),
        .used   (used_q),
        .found  (mf_found),
        .slot   (mf_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (submit && !game_over && guess_ok) state_d = GREEN;
            GREEN:   if (col_q == LAST_COL) state_d = YELLOW;
            YELLOW:  if (col_q == LAST_COL) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // new_game aborts any evaluation and beats a simultaneous submit
        if (new_game) state_d = IDLE;
    end

    always_comb begin
        busy        = (state_q != IDLE);
        load        = 1'b0;
        bad_guess   = 1'b0;
        green_step  = 1'b0;
        yellow_step = 1'b0;
        finish      = 1'b0;
        if (!new_game) begin
            case (state_q)
                IDLE: begin
                    load      = submit && !game_over && guess_ok;
                    bad_guess = submit && !game_over && !guess_ok;
                end
                GREEN:   green_step  = 1'b1;
                YELLOW:  yellow_step = 1'b1;
                DONE:    finish      = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q          <= '0;
            a_q          <= '0;
            col_q        <= '0;
            used_q       <= '0;
            colour_q     <= '0;
            result_q     <= '0;
            result_valid <= 1'b0;
            reject       <= 1'b0;
            row_index    <= '0;
            win          <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            result_valid <= finish;
            reject       <= bad_guess;
            if (new_game) begin
                row_index <= '0;
                win       <= 1'b0;
                game_over <= 1'b0;
            end
            if (load) begin
                g_q      <= guess_w;
                a_q      <= answer;
                used_q   <= '0;
                col_q    <= '0;
                colour_q <= '0;
            end
            if (green_step) begin
                if (g_q[col_q] == a_q[col_q]) begin
                    colour_q[col_q] <= COLOR_GREEN;
                    used_q[col_q]   <= 1'b1;
                end
                col_q <= col_inc;
            end
            if (yellow_step) begin
                if (colour_q[col_q] != COLOR_GREEN && mf_found) begin
                    colour_q[col_q] <= COLOR_YELLOW;
                    used_q          <= used_q | mf_slot;
                end
                col_q <= col_inc;
            end
            if (finish) begin
                result_q  <= result_d;
                row_index <= row_next;
                win       <= win | all_green;
                game_over <= all_green || (row_next == MAX_ROW);
            end
        end
    end

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator with a result scoreboard fed by an independent Wordle model.
module tb_guess_evaluator;

    logic        clk = 1'b0;
    logic        rst, new_game, submit;
    logic [24:0] guess, answer;
    logic        busy, result_valid, reject, win, game_over;
    logic [34:0] result;
    logic [2:0]  row_index;

    int checks   = 0;
    int errors   = 0;
    int rv_count = 0;
    logic [34:0] sb[$];

    guess_evaluator #(.MAX_GUESSES(6), .NUM_COLS(5)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .submit(submit),
        .guess(guess), .answer(answer), .busy(busy), .result_valid(result_valid),
        .result(result), .row_index(row_index), .reject(reject), .win(win),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] w(input int c0, c1, c2, c3, c4);
        return {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    // letter-count formulation of the duplicate rules
    function automatic logic [34:0] score(input logic [24:0] g, input logic [24:0] a);
        int          cnt[32];
        logic [1:0]  col[5];
        logic [4:0]  gl[5];
        logic [4:0]  al[5];
        logic [34:0] r;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i]  = g[i*5 +: 5];
            al[i]  = a[i*5 +: 5];
            col[i] = 2'd0;
        end
        for (int i = 0; i < 5; i++)
            if (gl[i] == al[i]) col[i] = 2'd2;
            else cnt[al[i]]++;
        for (int i = 0; i < 5; i++)
            if (col[i] != 2'd2 && cnt[gl[i]] > 0) begin
                col[i] = 2'd1;
                cnt[gl[i]]--;
            end
        r = '0;
        for (int i = 0; i < 5; i++) r[i*7 +: 7] = {col[i], gl[i]};
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (result_valid === 1'b1) begin
            rv_count++;
            if (sb.size() == 0) check("rv_unexpected", 64'(result_valid), 64'd0);
            else                check("result", 64'(result), 64'(sb.pop_front()));
        end
    end

    task automatic drive_submit(input logic [24:0] g, input logic [24:0] a);
        @(negedge clk);
        guess  = g;
        answer = a;
        submit = 1'b1;
        @(posedge clk);
        #1 submit = 1'b0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
    endtask

    task automatic run_guess(input string tag, input logic [24:0] g, input logic [24:0] a);
        int lat;
        bit seen;
        sb.push_back(score(g, a));
        drive_submit(g, a);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat  = 0;
        seen = 0;
        repeat (20) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                lat++;
                if (result_valid === 1'b1) seen = 1;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd11);
    endtask

    task automatic watch(input int n, output bit saw_reject);
        saw_reject = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (reject === 1'b1) saw_reject = 1;
        end
    endtask

    localparam logic [24:0] CRANE = 25'({5'd5, 5'd14, 5'd1, 5'd18, 5'd3});
    localparam logic [24:0] EERIE = 25'({5'd5, 5'd9, 5'd18, 5'd5, 5'd5});

    initial begin
        logic [24:0] gs[6];
        logic [24:0] as[6];
        logic [34:0] prev_res;
        int rv0;
        bit sr;

        rst = 1'b1; new_game = 1'b0; submit = 1'b0; guess = '0; answer = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, result_valid, reject, win, game_over, row_index}), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(negedge clk) rst = 1'b0;

        // exact match
        run_guess("crane", CRANE, CRANE);
        check("crane_win", 64'(win), 64'd1);
        check("crane_game_over", 64'(game_over), 64'd1);
        check("crane_row", 64'(row_index), 64'd1);
        @(posedge clk) #1;
        check("crane_busy_after", 64'(busy), 64'd0);

        // duplicate letters: last E claims the only E
        pulse_new_game();
        check("ng_cleared", 64'({win, game_over, row_index}), 64'd0);
        run_guess("eerie", EERIE, CRANE);
        check("eerie_cells", 64'(result),
              64'({2'd2, 5'd5, 2'd0, 5'd9, 2'd1, 5'd18, 2'd0, 5'd5, 2'd0, 5'd5}));
        check("eerie_row", 64'(row_index), 64'd1);
        check("eerie_win", 64'(win), 64'd0);
        @(posedge clk) #1;

        // malformed letters in column 2
        drive_submit(w(3, 18, 0, 14, 5), CRANE);
        check("rej0_pulse", 64'(reject), 64'd1);
        check("rej0_busy", 64'(busy), 64'd0);
        @(posedge clk) #1;
        check("rej0_one_cycle", 64'(reject), 64'd0);
        check("rej0_row", 64'(row_index), 64'd1);
        drive_submit(w(3, 18, 27, 14, 5), CRANE);
        check("rej27_pulse", 64'(reject), 64'd1);
        check("rej27_busy", 64'(busy), 64'd0);
        @(posedge clk) #1;
        check("rej27_one_cycle", 64'(reject), 64'd0);
        check("rej27_row", 64'(row_index), 64'd1);

        // six non-winning rows, then an ignored seventh
        pulse_new_game();
        gs = '{EERIE, w(1,2,2,5,25), w(14,1,3,18,5), w(26,26,26,26,26), w(3,18,1,14,11), EERIE};
        as = '{CRANE, CRANE, CRANE, CRANE, CRANE, w(19,16,5,5,4)};
        for (int i = 0; i < 6; i++) begin
            run_guess($sformatf("row%0d", i), gs[i], as[i]);
            check($sformatf("row%0d_index", i), 64'(row_index), 64'(i + 1));
            check($sformatf("row%0d_go", i), 64'(game_over), 64'(i == 5));
            @(posedge clk) #1;
        end
        check("six_win", 64'(win), 64'd0);
        rv0 = rv_count;
        drive_submit(w(1, 2, 3, 4, 5), CRANE);
        check("seventh_busy", 64'(busy), 64'd0);
        watch(15, sr);
        check("seventh_rv", 64'(rv_count - rv0), 64'd0);
        check("seventh_reject", 64'(sr), 64'd0);
        check("seventh_row", 64'(row_index), 64'd6);

        // submits while busy are ignored
        pulse_new_game();
        rv0 = rv_count;
        sb.push_back(score(w(18, 1, 3, 5, 19), CRANE));
        drive_submit(w(18, 1, 3, 5, 19), CRANE);
        @(posedge clk);
        @(posedge clk);
        drive_submit(w(1, 1, 1, 1, 1), CRANE);
        @(posedge clk);
        drive_submit(w(2, 2, 2, 2, 2), CRANE);
        watch(12, sr);
        check("busy_submit_rv", 64'(rv_count - rv0), 64'd1);
        check("busy_submit_reject", 64'(sr), 64'd0);
        check("busy_submit_row", 64'(row_index), 64'd1);
        prev_res = score(w(18, 1, 3, 5, 19), CRANE);

        // async reset in GREEN col 2
        drive_submit(w(3, 18, 1, 13, 16), CRANE);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({busy, result_valid, reject, win, game_over, row_index}), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        @(negedge clk) rst = 1'b0;

        // new_game abort in GREEN col 2
        run_guess("pre_abort", w(20, 18, 1, 9, 14), CRANE);
        prev_res = score(w(20, 18, 1, 9, 14), CRANE);
        @(posedge clk) #1;
        rv0 = rv_count;
        drive_submit(w(3, 18, 1, 13, 16), CRANE);
        @(posedge clk);
        @(posedge clk);
        pulse_new_game();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_row", 64'(row_index), 64'd0);
        watch(14, sr);
        check("abort_no_rv", 64'(rv_count - rv0), 64'd0);
        check("abort_result_held", 64'(result), 64'(prev_res));

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
